// File: rtl/clock_pkg.sv
// clock_pkg: set-mode state type and field limits shared by the wall-clock controller
package clock_pkg;
  typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN, SET_SEC} state_t;
  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;
endpackage

// File: rtl/clock_time_ctrl_time_field_counter.sv
// time_field_counter: mod-(MAX+1) field register with inc/dec/clear and wrap-carry
//   clk, rst : clock, asynchronous active-high reset
//   inc, dec : step up / step down (both together hold)
//   clr      : load zero, overrides inc/dec
//   val      : field value 0..MAX
//   carry    : combinational, high when an inc wraps MAX->0 this cycle
module time_field_counter #(
  parameter int W   = 6,
  parameter int MAX = 59
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] val,
  output logic         carry
);
  localparam logic [W-1:0] TOP = W'(MAX);
  assign carry = inc & ~dec & ~clr & (val == TOP);
  always_ff @(posedge clk or posedge rst)
    if (rst) val <= '0;
    else if (clr) val <= '0;
    else if (inc & ~dec) val <= (val == TOP) ? '0 : val + 1'b1;
    else if (dec & ~inc) val <= (val == '0) ? TOP : val - 1'b1;
endmodule

// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: timekeeping and four-state time-set controller for the wall clock
//   clk, reset       : system clock, asynchronous active-high reset
//   i_run_en, i_tick : global enable, one-second tick from the generator
//   i_mode/i_up/i_down : debounced one-cycle button pulses
//   o_run_en, o_freq : registered run enable and constant count to the generator
//   o_mode, sec, minute, hour : registered state and time fields
//   Macro CLOCK_CTRL_HOLD_EN: freeze time and pause the generator in set states.
module clock_time_ctrl
  import clock_pkg::*;
#(
  parameter int P_COUNT_BIT = 30,
  parameter int P_FREQ      = 100_000_000,
  parameter int P_SEC_BIT   = 6,
  parameter int P_MIN_BIT   = 6,
  parameter int P_HOUR_BIT  = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_run_en,
  input  logic                   i_tick,
  input  logic                   i_mode,
  input  logic                   i_up,
  input  logic                   i_down,
  output logic                   o_run_en,
  output logic [P_COUNT_BIT-1:0] o_freq,
  output logic [1:0]             o_mode,
  output logic [P_SEC_BIT-1:0]   sec,
  output logic [P_MIN_BIT-1:0]   minute,
  output logic [P_HOUR_BIT-1:0]  hour
);
  state_t state;
  logic in_set, up, dn, touch, tick_go, sec_c, min_c, hour_c;
  assign o_freq = P_COUNT_BIT'(P_FREQ);
  assign o_mode = state;
  always_comb begin
    in_set = state != RUN;
    // a mode pulse swallows any edit in the same cycle; up+down cancel
    up = i_up & ~i_down & ~i_mode & in_set;
    dn = i_down & ~i_up & ~i_mode & in_set;
`ifdef CLOCK_CTRL_HOLD_EN
    tick_go = i_tick & i_run_en & ~in_set;
`else
    // an edit drops a coincident tick entirely, carries included
    tick_go = i_tick & i_run_en & ~(up | dn);
`endif
    touch = tick_go | up | dn;
  end
  time_field_counter #(.W(P_SEC_BIT), .MAX(SEC_MAX)) u_sec (
    .clk(clk), .rst(reset),
    .inc(tick_go | (up && state == SET_SEC)),
    .dec(dn && state == SET_SEC),
    .clr(touch && sec > P_SEC_BIT'(SEC_MAX)),
    .val(sec), .carry(sec_c)
  );
  time_field_counter #(.W(P_MIN_BIT), .MAX(MIN_MAX)) u_min (
    .clk(clk), .rst(reset),
    .inc((tick_go & sec_c) | (up && state == SET_MIN)),
    .dec(dn && state == SET_MIN),
    .clr(touch && minute > P_MIN_BIT'(MIN_MAX)),
    .val(minute), .carry(min_c)
  );
  time_field_counter #(.W(P_HOUR_BIT), .MAX(HOUR_MAX)) u_hour (
    .clk(clk), .rst(reset),
    .inc((tick_go & sec_c & min_c) | (up && state == SET_HOUR)),
    .dec(dn && state == SET_HOUR),
    .clr(touch && hour > P_HOUR_BIT'(HOUR_MAX)),
    .val(hour), .carry(hour_c)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= RUN;
      o_run_en <= 1'b0;
    end else begin
      if (i_mode) state <= state_t'(2'(state) + 2'd1);
`ifdef CLOCK_CTRL_HOLD_EN
      o_run_en <= i_run_en & (state == RUN);
`else
      o_run_en <= i_run_en;
`endif
    end
endmodule

// File: tb/tb_clock_time_ctrl.sv
// tb_clock_time_ctrl: directed + random stimulus against a seconds-of-day reference model
module tb_clock_time_ctrl;
  logic clk = 1'b0, reset, i_run_en, i_tick, i_mode, i_up, i_down, o_run_en;
  logic [29:0] o_freq;
  logic [1:0] o_mode;
  logic [5:0] sec, minute;
  logic [4:0] hour;
`ifdef CLOCK_CTRL_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif
  int vec = 0, miss = 0;
  int mh = 0, mm = 0, ms = 0, mmode = 0;
  bit mrun = 0;

  clock_time_ctrl dut (
    .clk(clk), .reset(reset), .i_run_en(i_run_en), .i_tick(i_tick), .i_mode(i_mode),
    .i_up(i_up), .i_down(i_down), .o_run_en(o_run_en), .o_freq(o_freq), .o_mode(o_mode),
    .sec(sec), .minute(minute), .hour(hour)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag);
    vec++;
    assert (o_mode === 2'(mmode) && sec === 6'(ms) && minute === 6'(mm) && hour === 5'(mh)
            && o_run_en === mrun && o_freq === 30'd100_000_000)
    else begin
      miss++;
      $error("FAIL %s: got mode=%0d %0d:%0d:%0d run_en=%0b freq=%0d, want mode=%0d %0d:%0d:%0d run_en=%0b freq=100000000",
             tag, o_mode, hour, minute, sec, o_run_en, o_freq, mmode, mh, mm, ms, mrun);
    end
  endtask

  task automatic step(input bit tk, input bit md, input bit up, input bit dn, input bit run,
                      input string tag);
    int t, d;
    bit acc, ed;
    i_tick = tk; i_mode = md; i_up = up; i_down = dn; i_run_en = run;
    @(posedge clk);
    acc = tk && run && (!HOLD || mmode == 0);
    ed = !md && mmode != 0 && (up != dn);
    d = up ? 1 : -1;
    mrun = run && (!HOLD || mmode == 0);
    if (ed) begin
      if (mmode == 1) mh = (mh + d + 24) % 24;
      if (mmode == 2) mm = (mm + d + 60) % 60;
      if (mmode == 3) ms = (ms + d + 60) % 60;
    end else if (acc) begin
      t = (mh * 3600 + mm * 60 + ms + 1) % 86400;
      mh = t / 3600; mm = (t / 60) % 60; ms = t % 60;
    end
    if (md) mmode = (mmode + 1) % 4;
    #1;
    chk(tag);
    i_tick = 0; i_mode = 0; i_up = 0; i_down = 0;
  endtask

  initial begin
    reset = 1; i_run_en = 0; i_tick = 0; i_mode = 0; i_up = 0; i_down = 0;
    #12 chk("reset_init");
    @(posedge clk); #1 reset = 0;
    step(0, 0, 0, 0, 1, "run_en_after_release");
    repeat (3) step(1, 0, 0, 0, 1, "tick");
    reset = 1;
    #1 mh = 0; mm = 0; ms = 0; mmode = 0; mrun = 0;
    chk("reset_async");
    @(posedge clk); #1 chk("reset_held");
    reset = 0;
    step(0, 0, 0, 0, 1, "run_en_release");
    step(0, 1, 0, 0, 1, "mode_to_hour");
    step(0, 0, 0, 1, 1, "hour_down_wrap");
    step(0, 1, 1, 0, 1, "mode_with_up");
    step(0, 0, 1, 1, 1, "updown_cancel");
    step(0, 0, 0, 1, 1, "min_down_wrap");
    step(0, 0, 1, 0, 1, "min_up_wrap");
    step(0, 0, 0, 1, 1, "min_down_wrap2");
    step(0, 1, 0, 0, 1, "mode_to_sec");
    step(0, 0, 0, 1, 1, "sec_down_wrap");
    step(0, 0, 0, 1, 1, "sec_down");
    step(0, 1, 0, 0, 1, "mode_to_run");
    step(1, 0, 0, 0, 1, "tick_235959");
    step(1, 0, 0, 0, 1, "tick_rollover");
    vec++;
    assert ({hour, minute, sec} === 17'd0) else begin
      miss++; $error("FAIL rollover_zero: got %0d:%0d:%0d want 0:0:0", hour, minute, sec);
    end
    step(0, 1, 0, 0, 1, "enter_hour_hold");
    repeat (3) step(1, 0, 0, 0, 1, "tick_in_set_hour");
    step(0, 1, 0, 0, 1, "mode_to_min");
    step(0, 1, 0, 0, 1, "mode_to_sec2");
    for (int i = 0; i < 60 && ms != 10; i++) step(0, 0, 1, 0, 1, "sec_up");
    step(1, 0, 1, 0, 1, "tick_with_up");
    vec++;
    assert (sec === 6'd11) else begin
      miss++; $error("FAIL tick_up_single: got sec=%0d want 11", sec);
    end
    step(1, 1, 0, 0, 1, "tick_with_mode");
    repeat (3) step(1, 0, 0, 0, 0, "tick_run_en_off");
    step(0, 1, 0, 0, 0, "mode_off_hour");
    step(0, 1, 0, 0, 0, "mode_off_min");
    step(0, 0, 1, 0, 0, "min_up_run_en_off");
    step(0, 1, 0, 0, 1, "mode_to_sec3");
    step(0, 1, 0, 0, 1, "mode_to_run2");
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 9) != 0, "random");
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
